// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill FSMs and the memory arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_D = 2'd2,
    FILL_I = 2'd3
  } arb_state_t;

  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LAT     = 4;

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating burst counter with synchronous clear; one instance counts issues, one counts returns.
module arb_burst_counter #(
  parameter int LIMIT = 8,
  parameter int CNT_W = $clog2(LIMIT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Clear wins over increment; the count holds at LIMIT instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= '0;
    end else if (inc && (count_r < CNT_W'(LIMIT))) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates main memory between I-fill, D-fill and D write-through stores; a granted fill owns
// memory for its whole burst. Define CACHE_ARB_RR_EN to alternate between pending fills.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill_req,
  input  logic [ADDR_W-1:0] i_fill_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_fill_req,
  input  logic [ADDR_W-1:0] d_fill_addr,
  output logic              d_grant,
  output logic              d_data_valid,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [CNT_W-1:0] issue_cnt_s;
  logic [CNT_W-1:0] ret_cnt_s;
  logic             fill_s;
  logic             issuing_s;
  logic             ret_inc_s;
  logic             fill_last_s;
  logic             pick_i_s;

  assign fill_s      = (state_r == FILL_D) || (state_r == FILL_I);
  assign issuing_s   = fill_s && (issue_cnt_s < CNT_W'(BLOCK_WORDS));
  assign ret_inc_s   = fill_s && mem_rvalid;
  assign fill_last_s = ret_inc_s && (ret_cnt_s == CNT_W'(BLOCK_WORDS - 1));
  assign fill_data   = mem_rdata;

  arb_burst_counter #(.LIMIT(BLOCK_WORDS), .CNT_W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (fill_last_s),
    .inc   (issuing_s),
    .count (issue_cnt_s)
  );

  arb_burst_counter #(.LIMIT(BLOCK_WORDS), .CNT_W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (fill_last_s),
    .inc   (ret_inc_s),
    .count (ret_cnt_s)
  );

`ifdef CACHE_ARB_RR_EN
  logic last_i_r;

  // Remembers which side the last completed fill served; resets as if I went last so D goes first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_i_r <= 1'b1;
    end else if (fill_last_s) begin
      last_i_r <= (state_r == FILL_I);
    end else begin
      last_i_r <= last_i_r;
    end
  end

  assign pick_i_s = i_fill_req && (!d_fill_req || !last_i_r);
`else
  assign pick_i_s = i_fill_req && !d_fill_req;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and memory command decode; returns outside a fill are dropped
  always_comb begin
    state_nxt_s  = state_r;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    d_wr_ack     = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_r)
      IDLE: begin
        if (d_wr_req) begin
          state_nxt_s = WRITE;
        end else if (pick_i_s) begin
          state_nxt_s = FILL_I;
        end else if (d_fill_req) begin
          state_nxt_s = FILL_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_wdata   = d_wr_data;
        d_wr_ack    = 1'b1;
        state_nxt_s = IDLE;
      end
      FILL_D: begin
        d_grant      = 1'b1;
        d_data_valid = mem_rvalid;
        mem_en       = issuing_s;
        mem_addr     = issuing_s ? d_fill_addr : '0;
        state_nxt_s  = fill_last_s ? IDLE : FILL_D;
      end
      FILL_I: begin
        i_grant      = 1'b1;
        i_data_valid = mem_rvalid;
        mem_en       = issuing_s;
        mem_addr     = issuing_s ? i_fill_addr : '0;
        state_nxt_s  = fill_last_s ? IDLE : FILL_I;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule
